// File: rtl/auto_turn_sequencer.sv
// auto_turn_sequencer: timed left/right turn driver with a one-deep command slot.
// Optional macro AUTO_TURN_SETTLE_EN adds a SETTLE phase between the end of the
// drive and the done pulse; without it done follows the last drive cycle.
module auto_turn_sequencer #(
  parameter int QUARTER_CYCLES = 380,
  parameter int SETTLE_CYCLES  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
  input  logic [1:0] cmd_quarters,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       turn_left,
  output logic       turn_right,
  output logic       is_turning,
  output logic       done,
  output logic [1:0] quarters_left
);

  localparam int MAXC  = (QUARTER_CYCLES > SETTLE_CYCLES) ? QUARTER_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] QLOAD = CNT_W'(QUARTER_CYCLES - 1);
`ifdef AUTO_TURN_SETTLE_EN
  localparam logic [CNT_W-1:0] SLOAD = CNT_W'(SETTLE_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, TURN, SETTLE} state_t;

  typedef struct packed {
    logic       dir;
    logic [1:0] q;
  } cmd_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;        // cycles left in the current quarter, minus one
`ifdef AUTO_TURN_SETTLE_EN
  logic [CNT_W-1:0] scnt;       // settle cycles left, minus one
`endif
  cmd_t             pend;
  logic             pend_full;

  cmd_t             nxt;
  logic             nxt_vld;
  logic             acc_nz;
  logic             turn_last;
  logic             finish;
  logic             launch;

  // Handshake, next-command selection and end-of-turn decode.
  // A zero-quarter command completes the handshake but is never stored or started.
  // finish marks the cycle whose following cycle carries the done pulse; launch
  // starts a turn either from IDLE or straight out of finish with no IDLE gap.
  always_comb begin
    cmd_ready = enable & ~rst & ~abort & ~pend_full;
    acc_nz    = cmd_valid & cmd_ready & (cmd_quarters != 2'd0);
    nxt.dir   = pend_full ? pend.dir : cmd_dir;
    nxt.q     = pend_full ? pend.q   : cmd_quarters;
    nxt_vld   = pend_full | acc_nz;
    turn_last = (state == TURN) & (cnt == '0) & (quarters_left == 2'd1);
`ifdef AUTO_TURN_SETTLE_EN
    finish    = (state == SETTLE) & (scnt == '0);
`else
    finish    = (state == TURN) & (abort | turn_last);
`endif
    launch    = ((state == IDLE) | finish) & ~abort & nxt_vld;
  end

  // Sequencer FSM with registered outputs; rst and a low enable both flush
  // everything without producing a done pulse.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state         <= IDLE;
      cnt           <= '0;
`ifdef AUTO_TURN_SETTLE_EN
      scnt          <= '0;
`endif
      pend          <= '0;
      pend_full     <= 1'b0;
      turn_left     <= 1'b0;
      turn_right    <= 1'b0;
      is_turning    <= 1'b0;
      done          <= 1'b0;
      quarters_left <= 2'd0;
    end else begin
      done <= finish;
      if (launch) begin
        state         <= TURN;
        cnt           <= QLOAD;
        quarters_left <= nxt.q;
        turn_left     <= ~nxt.dir;
        turn_right    <= nxt.dir;
        is_turning    <= 1'b1;
        pend_full     <= 1'b0;
      end else if (finish) begin
        state         <= IDLE;
        turn_left     <= 1'b0;
        turn_right    <= 1'b0;
        is_turning    <= 1'b0;
        quarters_left <= 2'd0;
        pend_full     <= 1'b0;
      end else begin
        // pending slot: abort discards it, otherwise a new command parks here
        if (abort) begin
          pend_full <= 1'b0;
        end else if (acc_nz && state != IDLE) begin
          pend.dir  <= cmd_dir;
          pend.q    <= cmd_quarters;
          pend_full <= 1'b1;
        end
        case (state)
          TURN: begin
`ifdef AUTO_TURN_SETTLE_EN
            if (abort || turn_last) begin
              state         <= SETTLE;
              scnt          <= SLOAD;
              turn_left     <= 1'b0;
              turn_right    <= 1'b0;
              quarters_left <= 2'd0;
            end else if (cnt == '0) begin
              cnt           <= QLOAD;
              quarters_left <= quarters_left - 2'd1;
            end else begin
              cnt <= cnt - 1'b1;
            end
`else
            if (cnt == '0) begin
              cnt           <= QLOAD;
              quarters_left <= quarters_left - 2'd1;
            end else begin
              cnt <= cnt - 1'b1;
            end
`endif
          end
`ifdef AUTO_TURN_SETTLE_EN
          SETTLE: scnt <= scnt - 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auto_turn_sequencer.sv
// Directed bench for auto_turn_sequencer (QUARTER_CYCLES=4, SETTLE_CYCLES=2).
// Expected timing adapts to AUTO_TURN_SETTLE_EN: settle length 2 or 0.
module tb_auto_turn_sequencer;

`ifdef AUTO_TURN_SETTLE_EN
  localparam int SET = 2;
`else
  localparam int SET = 0;
`endif

  logic       clk, rst, enable, cmd_valid, cmd_dir, abort;
  logic [1:0] cmd_quarters;
  logic       cmd_ready, turn_left, turn_right, is_turning, done;
  logic [1:0] quarters_left;
  logic [5:0] obs, exp;
  int         n_chk, n_fail;

  auto_turn_sequencer #(.QUARTER_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir), .cmd_quarters(cmd_quarters), .cmd_ready(cmd_ready),
    .abort(abort), .turn_left(turn_left), .turn_right(turn_right),
    .is_turning(is_turning), .done(done), .quarters_left(quarters_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {turn_left, turn_right, is_turning, done, quarters_left};

  // Expected {left,right,is_turning,done,quarters_left} i cycles after acceptance.
  function automatic logic [5:0] exp_vec(input logic dir, input int q, input int i);
    int td;
    td = 4 * q;
    if (i >= 1 && i <= td) return {~dir, dir, 1'b1, 1'b0, 2'(q - (i - 1) / 4)};
    if (i > td && i <= td + SET) return 6'b001000;
    if (i == td + SET + 1) return 6'b000100;
    return 6'b000000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic d, input logic [1:0] q, input logic ab);
    cmd_valid    = v;
    cmd_dir      = d;
    cmd_quarters = q;
    abort        = ab;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1;
    drive(1'b1, 1'b0, 2'd1, 1'b0);
    tick; tick;
    n_chk++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_outputs got %b exp %b", obs, 6'b0); end
    n_chk++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", cmd_ready); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    tick;
    n_chk++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL post_reset_outputs got %b exp %b", obs, 6'b0); end
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_single(input logic d, input int q);
    for (int t = 0; t <= 4 * q + SET + 3; t++) begin
      if (t == 0) begin
        drive(1'b1, d, 2'(q), 1'b0);
        n_chk++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", cmd_ready); end
      end else begin
        drive(1'b0, 1'b0, 2'd0, 1'b0);
      end
      exp = exp_vec(d, q, t);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL single d=%0d q=%0d t=%0d got %b exp %b", d, q, t, obs, exp); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int dc;
    dc = 4 + SET + 1;
    for (int t = 0; t <= dc + 4 + SET + 2; t++) begin
      if (t == 0) drive(1'b1, 1'b0, 2'd1, 1'b0);
      else if (t == 1) begin
        drive(1'b1, 1'b1, 2'd1, 1'b0);
        n_chk++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_queue_ready got %b exp 1", cmd_ready); end
      end else if (t == 2) begin
        drive(1'b1, 1'b0, 2'd3, 1'b0);
        n_chk++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %b exp 0", cmd_ready); end
      end else drive(1'b0, 1'b0, 2'd0, 1'b0);
      if (t < dc) exp = exp_vec(1'b0, 1, t);
      else exp = exp_vec(1'b1, 1, t - dc + 1) | ((t == dc) ? 6'b000100 : 6'b000000);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL b2b t=%0d got %b exp %b", t, obs, exp); end
      tick;
    end
  endtask

  task automatic test_abort;
    for (int t = 0; t <= 3 + SET + 5; t++) begin
      if (t == 0) drive(1'b1, 1'b0, 2'd2, 1'b0);
      else if (t == 1) drive(1'b1, 1'b1, 2'd1, 1'b0);
      else if (t == 2) begin
        drive(1'b1, 1'b1, 2'd3, 1'b1);
        n_chk++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b exp 0", cmd_ready); end
      end else drive(1'b0, 1'b0, 2'd0, 1'b0);
      if (t == 1 || t == 2) exp = exp_vec(1'b0, 2, t);
      else if (t >= 3 && t < 3 + SET) exp = 6'b001000;
      else if (t == 3 + SET) exp = 6'b000100;
      else exp = 6'b000000;
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL abort t=%0d got %b exp %b", t, obs, exp); end
      tick;
    end
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_pending_cleared got %b exp 1", cmd_ready); end
    // abort while idle: blocks the handshake and changes nothing
    drive(1'b1, 1'b1, 2'd1, 1'b1);
    n_chk++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL idle_abort_ready got %b exp 0", cmd_ready); end
    tick;
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    n_chk++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL idle_abort_outputs got %b exp %b", obs, 6'b0); end
  endtask

  task automatic test_enable_low;
    for (int t = 0; t <= 14; t++) begin
      if (t == 0) drive(1'b1, 1'b1, 2'd2, 1'b0);
      else if (t == 1) drive(1'b1, 1'b0, 2'd1, 1'b0);
      else if (t == 3) begin
        enable = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        n_chk++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL enable_low_ready got %b exp 0", cmd_ready); end
      end else begin
        enable = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
      end
      exp = (t >= 1 && t <= 3) ? exp_vec(1'b1, 2, t) : 6'b000000;
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL enable_low t=%0d got %b exp %b", t, obs, exp); end
      tick;
    end
  endtask

  task automatic test_rst_mid;
    for (int t = 0; t <= 12; t++) begin
      rst = (t == 2);
      if (t == 0) drive(1'b1, 1'b0, 2'd1, 1'b0);
      else if (t == 1) drive(1'b1, 1'b1, 2'd2, 1'b0);
      else drive(1'b0, 1'b0, 2'd0, 1'b0);
      exp = (t >= 1 && t <= 2) ? exp_vec(1'b0, 1, t) : 6'b000000;
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL rst_mid t=%0d got %b exp %b", t, obs, exp); end
      tick;
    end
    rst = 1'b0;
  endtask

  task automatic test_null;
    for (int t = 0; t <= 8; t++) begin
      if (t == 0) begin
        drive(1'b1, 1'b1, 2'd0, 1'b0);
        n_chk++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL null_ready got %b exp 1", cmd_ready); end
      end else drive(1'b0, 1'b0, 2'd0, 1'b0);
      n_chk++;
      if (obs !== 6'b0) begin n_fail++; $display("FAIL null t=%0d got %b exp %b", t, obs, 6'b0); end
      tick;
    end
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL null_after_ready got %b exp 1", cmd_ready); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_quarters = 2'd0; abort = 1'b0;
    test_reset;
    test_single(1'b0, 1);
    test_single(1'b1, 2);
    test_single(1'b1, 3);
    test_back_to_back;
    test_abort;
    test_enable_low;
    test_rst_mid;
    test_null;
    test_single(1'b0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
